// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opsel codes, flag bit
// positions and FSM state encodings.
package alu_issue_ctrl_pkg;

  localparam logic [4:0] ALU_PASS = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_MUL  = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;
  localparam logic [4:0] ALU_POW  = 5'd8;

  localparam int ZF = 3;
  localparam int NF = 2;
  localparam int CF = 1;
  localparam int OF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Ops whose upper result half is architecturally written back to X.
  function automatic logic has_x_result(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_POW);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared 16-bit ALU: accepts one op, holds opsel until
// the ALU is ready (or a timeout), owns the ZNCO flags and pulses write-back.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter logic [4:0] IDLE_OP  = 5'd0,
  parameter int         MAX_WAIT = 64,
  parameter int         DST_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [15:0]      req_x,
  input  logic [DST_W-1:0] req_dst,
  input  logic             flag_load,
  input  logic [3:0]       flag_in,
  output logic [15:0]      alu_srcA,
  output logic [15:0]      alu_srcB,
  output logic [15:0]      alu_extra_X,
  output logic [4:0]       alu_opsel,
  input  logic [15:0]      alu_res,
  input  logic [15:0]      alu_extra_res,
  input  logic             alu_ready,
  input  logic [3:0]       alu_flag_next,
  output logic             alu_Cflag,
  output logic             alu_Oflag,
  output logic             wb_valid,
  output logic [DST_W-1:0] wb_dst,
  output logic [15:0]      wb_data,
  output logic             wb_x_valid,
  output logic [15:0]      wb_x_data,
  output logic             wb_err,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic [4:0]       op_q;
  logic [DST_W-1:0] dst_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             capture;

  assign capture = (state == ST_EXEC) && alu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= IDLE_OP;
      alu_opsel   <= IDLE_OP;
      alu_srcA    <= '0;
      alu_srcB    <= '0;
      alu_extra_X <= '0;
      dst_q       <= '0;
      wait_cnt    <= '0;
      flags       <= '0;
      wb_valid    <= 1'b0;
      wb_x_valid  <= 1'b0;
      wb_err      <= 1'b0;
      wb_data     <= '0;
      wb_x_data   <= '0;
    end else begin
      wb_valid   <= 1'b0;
      wb_x_valid <= 1'b0;
      wb_err     <= 1'b0;
      // A software flag load loses only to the ALU's own flag update.
      if (flag_load && !capture) begin
        flags <= flag_in;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            alu_opsel   <= req_op;
            alu_srcA    <= req_a;
            alu_srcB    <= req_b;
            alu_extra_X <= req_x;
            dst_q       <= req_dst;
            wait_cnt    <= '0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (alu_ready) begin
            wb_data    <= alu_res;
            wb_x_data  <= alu_extra_res;
            flags      <= alu_flag_next;
            wb_valid   <= 1'b1;
            wb_x_valid <= has_x_result(op_q);
            alu_opsel  <= IDLE_OP;
            state      <= ST_WB;
          end else if (wait_cnt == LAST_WAIT) begin
            wb_valid  <= 1'b1;
            wb_err    <= 1'b1;
            alu_opsel <= IDLE_OP;
            state     <= ST_WB;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          alu_opsel <= IDLE_OP;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign wb_dst    = dst_q;
  assign alu_Cflag = flags[CF];
  assign alu_Oflag = flags[OF];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: emulates the ALU, keeps a
// transaction-level expectation queue and compares the DUT every cycle.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int MAXW = 8;
  localparam int DW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [15:0]   req_a, req_b, req_x;
  logic [DW-1:0] req_dst;
  logic          flag_load;
  logic [3:0]    flag_in;
  logic [15:0]   alu_srcA, alu_srcB, alu_extra_X;
  logic [4:0]    alu_opsel;
  logic [15:0]   alu_res, alu_extra_res;
  logic          alu_ready;
  logic [3:0]    alu_flag_next;
  logic          alu_Cflag, alu_Oflag;
  logic          wb_valid;
  logic [DW-1:0] wb_dst;
  logic [15:0]   wb_data;
  logic          wb_x_valid;
  logic [15:0]   wb_x_data;
  logic          wb_err;
  logic [3:0]    flags;
  logic          busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.IDLE_OP(ALU_PASS), .MAX_WAIT(MAXW), .DST_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_x(req_x), .req_dst(req_dst),
    .flag_load(flag_load), .flag_in(flag_in),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_extra_X(alu_extra_X),
    .alu_opsel(alu_opsel), .alu_res(alu_res), .alu_extra_res(alu_extra_res),
    .alu_ready(alu_ready), .alu_flag_next(alu_flag_next),
    .alu_Cflag(alu_Cflag), .alu_Oflag(alu_Oflag),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_x_valid(wb_x_valid), .wb_x_data(wb_x_data), .wb_err(wb_err),
    .flags(flags), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] xres;
    logic [3:0]  fl;
  } alu_out_t;

  typedef struct {
    int            a_cyc;
    int            wb_cyc;
    logic [4:0]    op;
    logic [15:0]   a, b;
    logic [DW-1:0] dst;
    logic [15:0]   data, xdata;
    logic          xv, err;
    logic [3:0]    fl;
  } exp_t;

  // Arithmetic reference for the ALU the controller talks to.
  function automatic alu_out_t alu_calc(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] x);
    alu_out_t    o;
    logic [16:0] s;
    logic [31:0] p;
    o = '0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        o.res = s[15:0];
        o.fl[CF] = s[16];
        o.fl[OF] = (a[15] == b[15]) && (o.res[15] != a[15]);
      end
      ALU_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        o.res = s[15:0];
        o.fl[CF] = s[16];
        o.fl[OF] = (a[15] != b[15]) && (o.res[15] != a[15]);
      end
      ALU_MUL: begin
        p = {16'd0, a} * {16'd0, b};
        o.res = p[15:0];
        o.xres = p[31:16];
        o.fl[CF] = |o.xres;
        o.fl[OF] = |o.xres;
      end
      ALU_DIV: begin
        p = {x, a};
        if (b == 16'd0) begin
          o.res = 16'hFFFF;
          o.xres = a;
        end else begin
          o.res = 16'(p / {16'd0, b});
          o.xres = 16'(p % {16'd0, b});
        end
      end
      ALU_POW: begin
        p = 32'd1;
        for (int i = 0; i < 16; i++) if (i < int'(b)) p = p * {16'd0, a};
        o.res = p[15:0];
        o.xres = p[31:16];
        o.fl[CF] = |o.xres;
        o.fl[OF] = |o.xres;
      end
      default: o.res = a;
    endcase
    o.fl[ZF] = (o.res == 16'd0);
    o.fl[NF] = o.res[15];
    return o;
  endfunction

  // ALU emulation: result is combinational, ready after alu_lat cycles of a held opsel.
  int       alu_lat = 0;
  logic     alu_stuck = 1'b0;
  int       alu_cnt = 0;
  alu_out_t alu_o;

  always @(posedge clk) alu_cnt <= (alu_opsel == ALU_PASS) ? 0 : alu_cnt + 1;

  always_comb begin
    alu_o         = alu_calc(alu_opsel, alu_srcA, alu_srcB, alu_extra_X);
    alu_res       = alu_o.res;
    alu_extra_res = alu_o.xres;
    alu_flag_next = alu_o.fl;
    alu_ready     = (alu_opsel != ALU_PASS) && !alu_stuck && (alu_cnt >= alu_lat);
  end

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pow_hi = 0;
  logic started = 1'b0;
  exp_t q[$];

  logic [15:0] model_data, model_xdata;
  logic [3:0]  model_flags;

  logic [15:0] last_data, last_xdata;
  logic        last_xv, last_err;
  logic [3:0]  last_flags;
  int          last_wb_cyc;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (alu_opsel == ALU_POW) pow_hi++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the expectation queue.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (q.size() > 0 && cyc >= q[0].a_cyc) begin
        checkOutput("busy", busy, 1);
        checkOutput("req_ready", req_ready, 0);
        if (cyc < q[0].wb_cyc) begin
          checkOutput("exec_opsel", alu_opsel, q[0].op);
          checkOutput("exec_srcA", alu_srcA, q[0].a);
          checkOutput("exec_srcB", alu_srcB, q[0].b);
          checkOutput("exec_wb_valid", wb_valid, 0);
        end else begin
          checkOutput("wb_valid", wb_valid, 1);
          checkOutput("wb_opsel", alu_opsel, ALU_PASS);
          checkOutput("wb_dst", wb_dst, q[0].dst);
          checkOutput("wb_data", wb_data, q[0].data);
          checkOutput("wb_x_valid", wb_x_valid, q[0].xv);
          checkOutput("wb_err", wb_err, q[0].err);
          if (q[0].xv) checkOutput("wb_x_data", wb_x_data, q[0].xdata);
          checkOutput("wb_flags", flags, q[0].fl);
          checkOutput("alu_Cflag", alu_Cflag, q[0].fl[CF]);
          checkOutput("alu_Oflag", alu_Oflag, q[0].fl[OF]);
          last_data   = wb_data;
          last_xdata  = wb_x_data;
          last_xv     = wb_x_valid;
          last_err    = wb_err;
          last_flags  = flags;
          last_wb_cyc = cyc;
          void'(q.pop_front());
        end
      end else begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_req_ready", req_ready, 1);
        checkOutput("idle_opsel", alu_opsel, ALU_PASS);
        checkOutput("idle_wb_valid", wb_valid, 0);
      end
    end
  end

  // Issues one op at a negedge, runs it to completion and returns one cycle after WB.
  task automatic applyStimulus(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] x, input logic [DW-1:0] dst, input int lat,
                               input logic stuck, input logic fl_cap, output int acc_cyc);
    exp_t     e;
    alu_out_t r;
    alu_lat   = lat;
    alu_stuck = stuck;
    r = alu_calc(op, a, b, x);
    e.a_cyc  = cyc + 1;
    e.wb_cyc = e.a_cyc + (stuck ? MAXW : lat + 1);
    e.op = op; e.a = a; e.b = b; e.dst = dst;
    if (stuck) begin
      e.data = model_data; e.xdata = model_xdata; e.xv = 1'b0; e.err = 1'b1; e.fl = model_flags;
    end else begin
      e.data = r.res; e.xdata = r.xres; e.err = 1'b0; e.fl = r.fl;
      e.xv = (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_POW);
      model_data = r.res; model_xdata = r.xres; model_flags = r.fl;
    end
    q.push_back(e);
    checkOutput("req_ready_at_issue", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_x = x; req_dst = dst;
    @(negedge clk);
    req_valid = 1'b0;
    flag_in = 4'hF;
    while (cyc < e.wb_cyc) begin
      flag_load = fl_cap && (cyc == e.a_cyc + lat);
      @(negedge clk);
    end
    flag_load = 1'b0;
    flag_in = 4'h0;
    @(negedge clk);
    acc_cyc = e.a_cyc - 1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc_prev, p0;
    rst = 1'b1; req_valid = 1'b0; req_op = ALU_PASS; req_a = '0; req_b = '0; req_x = '0;
    req_dst = '0; flag_load = 1'b0; flag_in = '0;
    model_data = '0; model_xdata = '0; model_flags = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_opsel", alu_opsel, ALU_PASS);
    checkOutput("rst_flags", flags, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_x_valid", wb_x_valid, 0);
    checkOutput("rst_wb_err", wb_err, 0);
    checkOutput("rst_wb_data", wb_data, 0);
    checkOutput("rst_srcA", alu_srcA, 0);
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);

    $display("[TB] ADD overflow");
    applyStimulus(ALU_ADD, 16'h7FFF, 16'h0001, 16'h0, 3'd1, 0, 1'b0, 1'b0, acc);
    checkOutput("add_data", last_data, 16'h8000);
    checkOutput("add_flags", last_flags, 4'b0101);
    checkOutput("add_latency", last_wb_cyc - acc, 2);
    checkOutput("add_x_valid", last_xv, 0);
    acc_prev = acc;

    $display("[TB] MUL timeout");
    applyStimulus(ALU_MUL, 16'h0003, 16'h0004, 16'h0, 3'd6, 0, 1'b1, 1'b0, acc);
    checkOutput("b2b_accept", acc - acc_prev, 3);
    checkOutput("timeout_latency", last_wb_cyc - acc, 9);
    checkOutput("timeout_err", last_err, 1);
    checkOutput("timeout_x_valid", last_xv, 0);
    checkOutput("timeout_flags", last_flags, 4'b0101);
    checkOutput("timeout_data", last_data, 16'h8000);

    $display("[TB] MUL");
    applyStimulus(ALU_MUL, 16'h0100, 16'h0100, 16'h0, 3'd2, 0, 1'b0, 1'b0, acc);
    checkOutput("mul_data", last_data, 16'h0000);
    checkOutput("mul_x_valid", last_xv, 1);
    checkOutput("mul_x_data", last_xdata, 16'h0001);

    $display("[TB] POW multi-cycle");
    p0 = pow_hi;
    applyStimulus(ALU_POW, 16'h0003, 16'h0004, 16'h0, 3'd3, 5, 1'b0, 1'b0, acc);
    checkOutput("pow_opsel_cycles", pow_hi - p0, 6);
    checkOutput("pow_latency", last_wb_cyc - acc, 7);
    checkOutput("pow_data", last_data, 16'h0051);
    checkOutput("pow_x_valid", last_xv, 1);

    $display("[TB] DIV");
    applyStimulus(ALU_DIV, 16'h0000, 16'h0010, 16'h0001, 3'd4, 2, 1'b0, 1'b0, acc);
    checkOutput("div_data", last_data, 16'h1000);
    checkOutput("div_latency", last_wb_cyc - acc, 4);

    $display("[TB] flag_load in capture cycle and in idle");
    applyStimulus(ALU_SUB, 16'h0005, 16'h0005, 16'h0, 3'd7, 0, 1'b0, 1'b1, acc);
    checkOutput("sub_capture_flags", last_flags, 4'b1000);
    flag_load = 1'b1; flag_in = 4'b1111;
    @(negedge clk);
    flag_load = 1'b0; flag_in = 4'b0000;
    model_flags = 4'b1111;
    checkOutput("idle_flag_load", flags, 4'b1111);
    checkOutput("idle_flag_C", alu_Cflag, 1);
    checkOutput("idle_flag_O", alu_Oflag, 1);

    $display("[TB] reset during POW wait");
    started = 1'b0;
    alu_lat = 6; alu_stuck = 1'b0;
    req_valid = 1'b1; req_op = ALU_POW; req_a = 16'h0002; req_b = 16'h0003; req_dst = 3'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pow_mid_busy", busy, 1);
    checkOutput("pow_mid_opsel", alu_opsel, ALU_POW);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_flags", flags, 0);
    checkOutput("rst_mid_opsel", alu_opsel, ALU_PASS);
    checkOutput("rst_mid_wb_valid", wb_valid, 0);
    model_data = '0; model_xdata = '0; model_flags = '0;
    started = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] ADD after reset");
    applyStimulus(ALU_ADD, 16'h1234, 16'h0001, 16'h0, 3'd5, 0, 1'b0, 1'b0, acc);
    checkOutput("post_rst_add_data", last_data, 16'h1235);
    checkOutput("post_rst_add_latency", last_wb_cyc - acc, 2);
    checkOutput("post_rst_add_flags", last_flags, 4'b0000);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
